// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard and forwarding logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // Scoreboard states for the single in-flight MUL/DIV.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_e;

    // Operand source selects driven to the ID/EX operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // RV32 major opcodes that matter for source-register usage.
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // rs1 is read by everything except the U-type and JAL formats.
    function automatic logic uses_rs1(input logic valid, input logic [6:0] opcode);
        return valid && (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    endfunction

    // rs2 is only read by R-type ALU/M ops, stores and branches.
    function automatic logic uses_rs2(input logic valid, input logic [6:0] opcode);
        return valid && ((opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH));
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-source forward select: picks the nearest pipeline stage writing this register.
// Latency: combinational.
// Backpressure: none; x0 and unused sources always read the register file.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_addr_i,
    input  logic          src_used_i,
    input  logic [AW-1:0] exe_addr_i,
    input  logic          exe_en_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic          mem_en_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic          wb_en_i,
    output logic [1:0]    sel_o
);

    logic src_live;
    assign src_live = src_used_i && (src_addr_i != '0);

    // Priority EXE > MEM > WB so the youngest producer of the value wins.
    always_comb begin
        sel_o = FWD_RF;
        if (src_live) begin
            if (exe_en_i && (src_addr_i == exe_addr_i)) begin
                sel_o = FWD_EXE;
            end else if (mem_en_i && (src_addr_i == mem_addr_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_en_i && (src_addr_i == wb_addr_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage operand forwarding, load-use detection and single MUL/DIV scoreboard.
// Latency: selects/STALL combinational; scoreboard state and stall counter registered.
// Backpressure: STALL freezes PC/IF/ID and BUBBLE injects a NOP into ID/EX.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MUL_CYCLES     = 2,
    parameter int DIV_CYCLES     = 33,
    parameter int CNT_WIDTH      = $clog2(DIV_CYCLES + 1),
    parameter int PERF_WIDTH     = 32
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      ID_VALID,
    input  logic [6:0]                ID_OPCODE,
    input  logic                      ID_FUNCT7_0,
    input  logic [REG_ADDR_WIDTH-1:0] ID_ADDR1,
    input  logic [REG_ADDR_WIDTH-1:0] ID_ADDR2,
    input  logic [REG_ADDR_WIDTH-1:0] ID_RD,
    input  logic                      EXE_VALID,
    input  logic                      EXE_WRITE_EN,
    input  logic                      EXE_LOAD,
    input  logic                      EXE_MULDIV_START,
    input  logic                      EXE_IS_DIV,
    input  logic [REG_ADDR_WIDTH-1:0] EXE_ADDR,
    input  logic                      MEM_WRITE_EN,
    input  logic [REG_ADDR_WIDTH-1:0] MEM_ADDR,
    input  logic                      MEM_STORE,
    input  logic [REG_ADDR_WIDTH-1:0] MEM_RS2,
    input  logic                      WB_WRITE_EN,
    input  logic [REG_ADDR_WIDTH-1:0] WB_ADDR,
    output logic [1:0]                DATA1SEL,
    output logic [1:0]                DATA2SEL,
    output logic                      DATAMEMSEL,
    output logic                      STALL,
    output logic                      BUBBLE,
    output logic                      MULDIV_BUSY,
    output logic                      MULDIV_DONE,
    output logic [PERF_WIDTH-1:0]     STALL_COUNT
);

    localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);

    md_state_e                 state_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [REG_ADDR_WIDTH-1:0] md_dest_q;
    logic [PERF_WIDTH-1:0]     stall_cnt_q;
    logic [PERF_WIDTH-1:0]     stall_cnt_d;

    logic                 use1;
    logic                 use2;
    logic                 exe_fwd_en;
    logic [1:0]           fwd1;
    logic [1:0]           fwd2;
    logic                 load_use;
    logic                 md_active;
    logic                 md_done;
    logic                 md_dest_nz;
    logic                 raw1;
    logic                 raw2;
    logic                 waw;
    logic                 m_ext;
    logic                 sb_stall;
    logic                 stall_any;
    logic                 md_start;
    logic [CNT_WIDTH-1:0] md_load;

    // ------------------------------------------------------------------
    // Source usage and forwarding
    // ------------------------------------------------------------------
    assign use1 = uses_rs1(ID_VALID, ID_OPCODE);
    assign use2 = uses_rs2(ID_VALID, ID_OPCODE);

    // A load in EXE has no result yet, so it is never a forwarding source.
    assign exe_fwd_en = EXE_VALID && EXE_WRITE_EN && !EXE_LOAD;

    fwd_select #(.AW(REG_ADDR_WIDTH)) u_fwd1 (
        .src_addr_i (ID_ADDR1),
        .src_used_i (use1),
        .exe_addr_i (EXE_ADDR),
        .exe_en_i   (exe_fwd_en),
        .mem_addr_i (MEM_ADDR),
        .mem_en_i   (MEM_WRITE_EN),
        .wb_addr_i  (WB_ADDR),
        .wb_en_i    (WB_WRITE_EN),
        .sel_o      (fwd1)
    );

    fwd_select #(.AW(REG_ADDR_WIDTH)) u_fwd2 (
        .src_addr_i (ID_ADDR2),
        .src_used_i (use2),
        .exe_addr_i (EXE_ADDR),
        .exe_en_i   (exe_fwd_en),
        .mem_addr_i (MEM_ADDR),
        .mem_en_i   (MEM_WRITE_EN),
        .wb_addr_i  (WB_ADDR),
        .wb_en_i    (WB_WRITE_EN),
        .sel_o      (fwd2)
    );

    // Store data reaching MEM may still be in flight in WB.
    assign DATAMEMSEL = MEM_STORE && WB_WRITE_EN && (MEM_RS2 == WB_ADDR) && (MEM_RS2 != '0);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign load_use = EXE_VALID && EXE_LOAD && EXE_WRITE_EN && (EXE_ADDR != '0) &&
                      ((use1 && (ID_ADDR1 == EXE_ADDR)) || (use2 && (ID_ADDR2 == EXE_ADDR)));

    assign md_active  = (state_q != IDLE);
    assign md_done    = (state_q == DONE);
    assign md_dest_nz = (md_dest_q != '0);

    assign raw1  = use1 && md_dest_nz && (ID_ADDR1 == md_dest_q);
    assign raw2  = use2 && md_dest_nz && (ID_ADDR2 == md_dest_q);
    assign waw   = ID_VALID && (ID_RD == md_dest_q);
    assign m_ext = ID_VALID && (ID_OPCODE == OP_RTYPE) && ID_FUNCT7_0;

    // In DONE the result is on the WB port, so RAW is satisfied by forwarding;
    // WAW and a second M op must still wait until the scoreboard is free.
    assign sb_stall = md_active && ID_VALID &&
                      ((!md_done && (raw1 || raw2)) || waw || m_ext);

    assign stall_any = load_use || sb_stall;

    assign STALL  = stall_any;
    assign BUBBLE = stall_any;

    // The MUL/DIV result overrides any stage select for its destination.
    assign DATA1SEL = (md_done && raw1) ? FWD_WB : fwd1;
    assign DATA2SEL = (md_done && raw2) ? FWD_WB : fwd2;

    assign MULDIV_BUSY = md_active;
    assign MULDIV_DONE = md_done;

    // ------------------------------------------------------------------
    // MUL/DIV scoreboard
    // ------------------------------------------------------------------
    assign md_start = EXE_VALID && EXE_MULDIV_START;
    assign md_load  = EXE_IS_DIV ? DIV_LOAD : MUL_LOAD;

    // Scoreboard FSM: count down the unit latency, pulse DONE for one cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            md_dest_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md_start) begin
                        cnt_q     <= md_load;
                        md_dest_q <= EXE_ADDR;
                        state_q   <= (md_load == '0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q <= CNT_WIDTH'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle performance counter (saturating)
    // ------------------------------------------------------------------
    assign stall_cnt_d = (stall_any && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    // Count every stalled cycle once, regardless of how many hazards caused it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_COUNT = stall_cnt_q;

endmodule
